// File: rtl/pe_traffic_gen.sv
// Per-node synthetic NoC traffic generator and sink.
// Injects numPackets rate-limited packets and counts/validates ejected packets.
module pe_traffic_gen #(
  parameter int unsigned X          = 10,
  parameter int unsigned Y          = 10,
  parameter int unsigned x_size     = $clog2(X),
  parameter int unsigned y_size     = $clog2(Y),
  parameter int unsigned data_width = 256,
  parameter int unsigned numPackets = 1000,
  parameter int unsigned rate       = 32,
  parameter string       pat        = "RANDOM",
  parameter int unsigned cur_x      = 0,
  parameter int unsigned cur_y      = 0,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                enableSend,
  output logic                                r_valid_pe,
  output logic [x_size+y_size+data_width-1:0] r_data_pe,
  input  logic                                r_ready_pe,
  input  logic                                w_valid_pe,
  input  logic [x_size+y_size+data_width-1:0] w_data_pe,
  output logic                                done,
  output logic [31:0]                         receiveCount,
  output logic                                addr_err
);

  localparam int unsigned       PW     = x_size + y_size + data_width;
  localparam int unsigned       TW     = (rate > 1) ? $clog2(rate) : 1;
  localparam bit                NBR    = (pat == "NEIGHBOUR");
  localparam logic [x_size-1:0] CUR_X  = x_size'(cur_x);
  localparam logic [y_size-1:0] CUR_Y  = y_size'(cur_y);
  localparam logic [x_size-1:0] NBR_X  = x_size'((cur_x + 1) % X);
  localparam logic [15:0]       SRC_ID = 16'(cur_y * X + cur_x);
  localparam logic [31:0]       NPKT   = 32'(numPackets);
  localparam logic [TW-1:0]     TMAX   = TW'(rate - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      tokens_q, tokens_d;
  logic [31:0]     issued_q, issued_d;
  logic [31:0]     sent_q, sent_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            valid_q, valid_d;
  logic [PW-1:0]   data_q, data_d;
  logic            done_q, done_d;
  logic [31:0]     rcv_q, rcv_d;
  logic            err_q, err_d;

  logic                  run_en_c;
  logic                  tick_c;
  logic                  issue_c;
  logic                  xfer_c;
  logic [4:0]            tok_sum_c;
  logic [15:0]           lfsr_next_c;
  logic [x_size-1:0]     dx_raw_c;
  logic [x_size-1:0]     dx_c;
  logic [y_size-1:0]     dy_c;
  logic [data_width-1:0] payload_c;
  logic                  unused_c;

  // Destination selection and payload assembly for the next packet.
  always_comb begin
    lfsr_next_c = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    dx_raw_c    = x_size'(32'(lfsr_q[7:0]) % X);
    dy_c        = y_size'(32'(lfsr_q[15:8]) % Y);
    dx_c        = dx_raw_c;
    if (NBR) begin
      dx_c = NBR_X;
      dy_c = CUR_Y;
    end else if ((dx_raw_c == CUR_X) && (dy_c == CUR_Y)) begin
      dx_c = x_size'((32'(dx_raw_c) + 32'd1) % X);
    end
    payload_c        = '0;
    payload_c[31:0]  = issued_q;
    payload_c[47:32] = SRC_ID;
  end

  // Token timer, issue/handshake control, FSM and receive accounting.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    tokens_d = tokens_q;
    issued_d = issued_q;
    sent_d   = sent_q;
    lfsr_d   = lfsr_q;
    valid_d  = valid_q;
    data_d   = data_q;
    done_d   = done_q;
    rcv_d    = rcv_q;
    err_d    = err_q;

    run_en_c = start & enableSend;
    tick_c   = 1'b0;
    xfer_c   = valid_q & r_ready_pe;
    issue_c  = (state_q == RUN) && run_en_c && !valid_q &&
               (tokens_q != 4'd0) && (issued_q < NPKT);

    if (run_en_c) begin
      if (timer_q == TMAX) begin
        timer_d = '0;
        tick_c  = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end

    // issue_c implies tokens_q > 0, so the subtraction cannot underflow.
    tok_sum_c = 5'(tokens_q) + 5'(tick_c) - 5'(issue_c);
    tokens_d  = (tok_sum_c > 5'd15) ? 4'd15 : tok_sum_c[3:0];

    if (issue_c) begin
      valid_d  = 1'b1;
      data_d   = {payload_c, dy_c, dx_c};
      issued_d = issued_q + 32'd1;
      lfsr_d   = lfsr_next_c;
    end

    if (xfer_c) begin
      valid_d = 1'b0;
      sent_d  = sent_q + 32'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (run_en_c) state_d = RUN;
      end
      RUN: begin
        if (xfer_c && ((sent_q + 32'd1) == NPKT)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (w_valid_pe) begin
      if (rcv_q != '1) rcv_d = rcv_q + 32'd1;
      if ((w_data_pe[x_size-1:0] != CUR_X) ||
          (w_data_pe[x_size+y_size-1:x_size] != CUR_Y)) begin
        err_d = 1'b1;
      end
    end
  end

  assign unused_c = ^w_data_pe[PW-1:x_size+y_size];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      tokens_q <= '0;
      issued_q <= '0;
      sent_q   <= '0;
      lfsr_q   <= SEED;
      valid_q  <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
      rcv_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      tokens_q <= tokens_d;
      issued_q <= issued_d;
      sent_q   <= sent_d;
      lfsr_q   <= lfsr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      done_q   <= done_d;
      rcv_q    <= rcv_d;
      err_q    <= err_d;
    end
  end

  assign r_valid_pe   = valid_q;
  assign r_data_pe    = data_q;
  assign done         = done_q;
  assign receiveCount = rcv_q;
  assign addr_err     = err_q;

endmodule

// File: tb/tb_pe_traffic_gen.sv
// Self-checking bench for pe_traffic_gen: a NEIGHBOUR node at (1,2) and a RANDOM node at (0,0)
// on a 4x4 mesh, checked against a packet scoreboard and a receive vector table.
module tb_pe_traffic_gen;

  localparam int PW = 68;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          wv;
  logic [PW-1:0] wd;

  logic          start_n, en_n, ready_n, rv_n, done_n, ae_n;
  logic [PW-1:0] rd_n;
  logic [31:0]   rc_n;

  logic          start_r, en_r, ready_r, rv_r, done_r, ae_r;
  logic [PW-1:0] rd_r;
  logic [31:0]   rc_r;

  pe_traffic_gen #(
    .X(4), .Y(4), .data_width(64), .numPackets(8), .rate(4),
    .pat("NEIGHBOUR"), .cur_x(1), .cur_y(2), .SEED(16'hACE1)
  ) u_nb (
    .clk(clk), .rst(rst), .start(start_n), .enableSend(en_n),
    .r_valid_pe(rv_n), .r_data_pe(rd_n), .r_ready_pe(ready_n),
    .w_valid_pe(wv), .w_data_pe(wd),
    .done(done_n), .receiveCount(rc_n), .addr_err(ae_n)
  );

  pe_traffic_gen #(
    .X(4), .Y(4), .data_width(64), .numPackets(200), .rate(1),
    .pat("RANDOM"), .cur_x(0), .cur_y(0), .SEED(16'hACE1)
  ) u_rnd (
    .clk(clk), .rst(rst), .start(start_r), .enableSend(en_r),
    .r_valid_pe(rv_r), .r_data_pe(rd_r), .r_ready_pe(ready_r),
    .w_valid_pe(wv), .w_data_pe(wd),
    .done(done_r), .receiveCount(rc_r), .addr_err(ae_r)
  );

  typedef struct {
    logic rst;
    logic wv;
    int   dx;
    int   dy;
    int   exp_rc;
    logic exp_err;
  } rx_vec_t;

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] exp_r[$];
  int            hs_cyc[$];
  int            first_v;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input int dx, input int dy, input int seq, input int src);
    logic [63:0] p;
    p        = '0;
    p[31:0]  = 32'(seq);
    p[47:32] = 16'(src);
    return {p, 2'(dy), 2'(dx)};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start_n = 1'b0; en_n = 1'b0; ready_n = 1'b0;
    start_r = 1'b0; ready_r = 1'b0; wv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic fill_nb();
    exp_q.delete();
    for (int s = 0; s < 8; s++) exp_q.push_back(mk(2, 2, s, 9));
  endtask

  // Drives start/ready windows per cycle and scores every handshake of the NEIGHBOUR node.
  task automatic run_nb(input int npk, input int maxc, input int rlo_a, input int rlo_b,
                        input int slo_a, input int slo_b);
    int            cyc;
    logic          held;
    logic [PW-1:0] hdat;
    cyc = 0; held = 1'b0; hdat = '0; first_v = -1;
    hs_cyc.delete();
    en_n    = 1'b1;
    start_n = !(cyc >= slo_a && cyc < slo_b);
    ready_n = !(cyc >= rlo_a && cyc < rlo_b);
    while (hs_cyc.size() < npk && cyc < maxc) begin
      @(negedge clk);
      cyc++;
      if (rv_n && first_v < 0) first_v = cyc;
      if (held) chk("hold_stable", 128'({rv_n, rd_n}), 128'({1'b1, hdat}));
      start_n = !(cyc >= slo_a && cyc < slo_b);
      ready_n = !(cyc >= rlo_a && cyc < rlo_b);
      if (rv_n && ready_n) begin
        if (exp_q.size() > 0) chk("nb_pkt", 128'(rd_n), 128'(exp_q.pop_front()));
        hs_cyc.push_back(cyc);
        if (hs_cyc.size() == npk) chk("done_before_last", 128'(done_n), 128'(0));
      end
      held = rv_n && !ready_n;
      hdat = rd_n;
    end
    chk("nb_hs_count", 128'(hs_cyc.size()), 128'(npk));
    @(negedge clk);
    chk("done_after_last", 128'(done_n), 128'(1));
    chk("valid_after_last", 128'(rv_n), 128'(0));
    chk("nb_sb_empty", 128'(exp_q.size()), 128'(0));
  endtask

  task automatic check_hs(input string tag, input int e[8]);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_hs%0d", tag, i), 128'((i < hs_cyc.size()) ? hs_cyc[i] : -1), 128'(e[i]));
  endtask

  // Reference destinations follow the LFSR sequence from SEED, one step per packet.
  task automatic run_rnd(input int n);
    logic [15:0] l;
    int          dx, dy, cyc, got, self_hits, last;
    exp_r.delete();
    l = 16'hACE1;
    for (int s = 0; s < n; s++) begin
      dx = int'(l[7:0]) % 4;
      dy = int'(l[15:8]) % 4;
      if (dx == 0 && dy == 0) dx = 1;
      exp_r.push_back(mk(dx, dy, s, 0));
      l = lfsr_step(l);
    end
    cyc = 0; got = 0; self_hits = 0; last = -1;
    en_r = 1'b1; start_r = 1'b1; ready_r = 1'b1;
    while (got < n && cyc < 4 * n + 50) begin
      @(negedge clk);
      cyc++;
      if (rv_r) begin
        if (rd_r[3:0] == 4'h0) self_hits++;
        if (exp_r.size() > 0) chk("rnd_pkt", 128'(rd_r), 128'(exp_r.pop_front()));
        got++;
        last = cyc;
      end
    end
    chk("rnd_count", 128'(got), 128'(n));
    chk("rnd_last_hs_cyc", 128'(last), 128'(2 * n));
    chk("rnd_self_dest", 128'(self_hits), 128'(0));
    @(negedge clk);
    chk("rnd_done", 128'(done_r), 128'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time budget exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int      exp1[8];
    int      exp2[8];
    int      exp6[8];
    rx_vec_t rxv[15];

    exp1 = '{5, 9, 13, 17, 21, 25, 29, 33};
    exp2 = '{80, 82, 84, 86, 88, 90, 92, 94};
    exp6 = '{5, 9, 17, 27, 31, 35, 39, 43};
    rxv = '{
      '{1'b1, 1'b0, 0, 0, 0, 1'b0},
      '{1'b0, 1'b1, 1, 2, 1, 1'b0},
      '{1'b0, 1'b1, 1, 2, 2, 1'b0},
      '{1'b0, 1'b0, 3, 3, 2, 1'b0},
      '{1'b0, 1'b1, 1, 2, 3, 1'b0},
      '{1'b0, 1'b1, 1, 2, 4, 1'b0},
      '{1'b0, 1'b1, 1, 2, 5, 1'b0},
      '{1'b0, 1'b1, 3, 3, 6, 1'b1},
      '{1'b0, 1'b0, 0, 0, 6, 1'b1},
      '{1'b0, 1'b0, 1, 2, 6, 1'b1},
      '{1'b1, 1'b0, 0, 0, 0, 1'b0},
      '{1'b0, 1'b1, 1, 3, 1, 1'b1},
      '{1'b1, 1'b0, 0, 0, 0, 1'b0},
      '{1'b0, 1'b1, 2, 2, 1, 1'b1},
      '{1'b0, 1'b0, 1, 2, 1, 1'b1}
    };

    rst = 1'b1; wv = 1'b0; wd = '0;
    start_n = 1'b0; en_n = 1'b0; ready_n = 1'b0;
    start_r = 1'b0; en_r = 1'b1; ready_r = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(rv_n), 128'(0));
    chk("rst_data", 128'(rd_n), 128'(0));
    chk("rst_done", 128'(done_n), 128'(0));
    chk("rst_rcount", 128'(rc_n), 128'(0));
    chk("rst_addr_err", 128'(ae_n), 128'(0));
    chk("rst_rnd_valid", 128'(rv_r), 128'(0));
    chk("rst_rnd_done", 128'(done_r), 128'(0));
    rst = 1'b0;

    // Free-flowing NEIGHBOUR run.
    fill_nb();
    run_nb(8, 100, 0, 0, 0, 0);
    chk("t1_first_valid", 128'(first_v), 128'(5));
    check_hs("t1", exp1);

    // Back-pressure long enough for tokens to saturate, then a 2-cycle burst.
    do_reset();
    fill_nb();
    run_nb(8, 200, 0, 80, 0, 0);
    chk("t2_first_valid", 128'(first_v), 128'(5));
    check_hs("t2", exp2);

    // start low for 10 cycles while a held packet completes; timer must freeze.
    do_reset();
    fill_nb();
    run_nb(8, 150, 13, 17, 13, 23);
    check_hs("t6", exp6);

    // Receive path vectors.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      rst = rxv[i].rst;
      wv  = rxv[i].wv;
      wd  = {$urandom(), $urandom(), 2'(rxv[i].dy), 2'(rxv[i].dx)};
      @(negedge clk);
      chk($sformatf("rx%0d_count", i), 128'(rc_n), 128'(rxv[i].exp_rc));
      chk($sformatf("rx%0d_err", i), 128'(ae_n), 128'(rxv[i].exp_err));
    end
    rst = 1'b0; wv = 1'b0;

    // RANDOM destinations.
    do_reset();
    run_rnd(200);

    // Reset mid-run with a held packet, then the sequence must restart from SEED.
    do_reset();
    start_r = 1'b1; ready_r = 1'b1;
    repeat (20) @(negedge clk);
    ready_r = 1'b0;
    for (int i = 0; i < 10 && !rv_r; i++) @(negedge clk);
    chk("mid_pre_valid", 128'(rv_r), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 128'(rv_r), 128'(0));
    chk("mid_rst_data", 128'(rd_r), 128'(0));
    chk("mid_rst_done", 128'(done_r), 128'(0));
    chk("mid_rst_rcount", 128'(rc_r), 128'(0));
    chk("mid_rst_addr_err", 128'(ae_r), 128'(0));
    rst = 1'b0; start_r = 1'b0;
    @(negedge clk);
    run_rnd(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
